// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: synchroniser, glitch filter (compiled in with EDGE_DET_FILTER_EN),
// registered rising/falling edge pulses, sticky pending/overflow flags and an aggregated irq.
module multi_edge_detector #(
    parameter int WIDTH         = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sig,
    input  logic [WIDTH-1:0] pos_en,
    input  logic [WIDTH-1:0] neg_en,
    input  logic [WIDTH-1:0] evt_clr,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] pos_edge,
    output logic [WIDTH-1:0] neg_edge,
    output logic [WIDTH-1:0] pending,
    output logic [WIDTH-1:0] overflow,
    output logic             irq
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("multi_edge_detector: WIDTH must be 1..32");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("multi_edge_detector: SYNC_STAGES must be 2..4");
    end
    if (FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_bad_filter
        $error("multi_edge_detector: FILTER_CYCLES must be 1..255");
    end

    logic [SYNC_STAGES-1:0][WIDTH-1:0] syncQ;
    logic [WIDTH-1:0] sigS;
    logic [WIDTH-1:0] levelQ, levelD;
    logic [WIDTH-1:0] prevQ;
    logic [WIDTH-1:0] posQ, posD;
    logic [WIDTH-1:0] negQ, negD;
    logic [WIDTH-1:0] pendQ, pendD;
    logic [WIDTH-1:0] ovfQ, ovfD;
    logic [WIDTH-1:0] evtD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncQ <= '0;
        end else begin
            syncQ <= {syncQ[SYNC_STAGES-2:0], sig};
        end
    end

    assign sigS = syncQ[SYNC_STAGES-1];

`ifdef EDGE_DET_FILTER_EN
    localparam int CW = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

    logic [WIDTH-1:0][CW-1:0] cntQ, cntD;

    // A level change is accepted only after the mismatch has persisted FILTER_CYCLES clocks.
    always_comb begin
        cntD   = cntQ;
        levelD = levelQ;
        for (int c = 0; c < WIDTH; c++) begin
            if (sigS[c] == levelQ[c]) begin
                cntD[c] = '0;
            end else if (cntQ[c] == CNT_LAST) begin
                levelD[c] = sigS[c];
                cntD[c]   = '0;
            end else begin
                cntD[c] = cntQ[c] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cntQ <= '0;
        end else begin
            cntQ <= cntD;
        end
    end
`else
    assign levelD = sigS;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            levelQ <= '0;
        end else begin
            levelQ <= levelD;
        end
    end

    assign posD = levelQ & ~prevQ & pos_en;
    assign negD = ~levelQ & prevQ & neg_en;
    assign evtD = posD | negD;

    // A new edge wins over a coincident clear; overflow only counts edges on an uncleared pending.
    assign pendD = evtD | (pendQ & ~evt_clr);
    assign ovfD  = (evtD & pendQ & ~evt_clr) | (ovfQ & ~evt_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prevQ <= '0;
            posQ  <= '0;
            negQ  <= '0;
            pendQ <= '0;
            ovfQ  <= '0;
        end else begin
            prevQ <= levelQ;
            posQ  <= posD;
            negQ  <= negD;
            pendQ <= pendD;
            ovfQ  <= ovfD;
        end
    end

    assign level    = levelQ;
    assign pos_edge = posQ;
    assign neg_edge = negQ;
    assign pending  = pendQ;
    assign overflow = ovfQ;
    assign irq      = |pendQ;

endmodule
